// File: rtl/rv32im_exec_slice_pkg.sv
// Shared definitions for the RV32IM execute slice: opcode constants,
// ALU operation encoding, immediate-format and writeback-select encodings,
// the decoded control bundle, and the base ALU-op mapping helper.
package rv32im_exec_slice_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned REG_AW = 5;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_AND    = 5'd2,
    ALU_OR     = 5'd3,
    ALU_XOR    = 5'd4,
    ALU_SLL    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_SLT    = 5'd8,
    ALU_SLTU   = 5'd9,
    ALU_MUL    = 5'd10,
    ALU_MULH   = 5'd11,
    ALU_MULHSU = 5'd12,
    ALU_MULHU  = 5'd13,
    ALU_DIV    = 5'd14,
    ALU_DIVU   = 5'd15,
    ALU_REM    = 5'd16,
    ALU_REMU   = 5'd17,
    ALU_PASSB  = 5'd18
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  // Decoded control for one instruction
  typedef struct packed {
    logic        reg_write;
    result_src_e result_src;
    logic        mem_write;
    logic        alu_src;    // 1: B operand is the immediate
    logic        src_a_pc;   // 1: A operand is the PC
    logic        branch;
    logic        jump;
    logic        jalr;       // target comes from the ALU, not pc+imm
    logic        illegal;
    imm_src_e    imm_src;
    alu_op_e     alu_op;
  } ctrl_t;

  // Base-ISA ALU op from funct3; alt selects SUB (000) or SRA (101)
  function automatic alu_op_e base_alu_op(input logic [2:0] funct3,
                                          input logic       alt);
    alu_op_e op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32im_exec_slice_add32.sv
// 32-bit combinational adder used for the PC-relative address paths.
// Ports: a, b (addends) -> sum (a + b, carry-out discarded).
module rv32im_exec_slice_add32
  import rv32im_exec_slice_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/rv32im_exec_slice.sv
// RV32IM decode-and-execute slice: decodes the instruction, runs the ALU,
// resolves branch/jump redirect and registers the results toward MEM.
// Ports: clk, reset (async active-low); valid_i/instr_i/pc_i and forwarded
// operands rs1_data_i/rs2_data_i/imm_i in; imm_src_o is combinational back
// to the immediate extender; all other outputs are registered EX/MEM fields.
module rv32im_exec_slice
  import rv32im_exec_slice_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic [XLEN-1:0]   instr_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  input  logic [XLEN-1:0]   imm_i,
  output logic [2:0]        imm_src_o,
  output logic [XLEN-1:0]   alu_result_o,
  output logic [XLEN-1:0]   write_data_o,
  output logic [XLEN-1:0]   pc_plus4_o,
  output logic [XLEN-1:0]   pc_target_o,
  output logic              pcsrc_o,
  output logic              reg_write_o,
  output logic [1:0]        result_src_o,
  output logic              mem_write_o,
  output logic [REG_AW-1:0] rd_o,
  output logic              illegal_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  ctrl_t      ctrl;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];

  // Register-index and funct7 bits not needed here (operands arrive forwarded)
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr_i[31], instr_i[29:26], instr_i[24:15]};

  // Control decode
  always_comb begin
    ctrl            = '0;
    ctrl.result_src = RES_ALU;
    ctrl.imm_src    = IMM_I;
    ctrl.alu_op     = ALU_ADD;
    case (opcode)
      OP_R: begin
        ctrl.reg_write = 1'b1;
        if (instr_i[25]) begin
          ctrl.alu_op = alu_op_e'(5'(ALU_MUL) + 5'(funct3));
        end else begin
          ctrl.alu_op = base_alu_op(funct3, instr_i[30]);
        end
      end
      OP_I_ALU: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        // bit 30 is an immediate bit except for the shift-right encodings
        ctrl.alu_op    = base_alu_op(funct3, (funct3 == 3'b101) && instr_i[30]);
      end
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_MEM;
        ctrl.alu_src    = 1'b1;
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.imm_src   = IMM_S;
      end
      OP_BRANCH: begin
        // SUB drives the zero flag used for EQ/NE
        ctrl.branch  = 1'b1;
        ctrl.imm_src = IMM_B;
        ctrl.alu_op  = ALU_SUB;
      end
      OP_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_PC4;
        ctrl.jump       = 1'b1;
        ctrl.imm_src    = IMM_J;
      end
      OP_JALR: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_PC4;
        ctrl.jump       = 1'b1;
        ctrl.jalr       = 1'b1;
        ctrl.alu_src    = 1'b1;
      end
      OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.imm_src   = IMM_U;
        ctrl.alu_op    = ALU_PASSB;
      end
      OP_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.src_a_pc  = 1'b1;
        ctrl.imm_src   = IMM_U;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

  assign imm_src_o = ctrl.imm_src;

  // ALU
  logic [XLEN-1:0]   src_a;
  logic [XLEN-1:0]   src_b;
  logic [XLEN-1:0]   alu_res;
  logic [2*XLEN-1:0] prod_ss;
  logic [2*XLEN-1:0] prod_su;
  logic [2*XLEN-1:0] prod_uu;
  logic              div_zero;
  logic              div_ovf;
  logic              zero;

  assign src_a = ctrl.src_a_pc ? pc_i : rs1_data_i;
  assign src_b = ctrl.alu_src ? imm_i : rs2_data_i;

  // Sign/zero-extend to 64 bits; the low 64 bits of the product are exact
  assign prod_ss = {{XLEN{src_a[XLEN-1]}}, src_a} * {{XLEN{src_b[XLEN-1]}}, src_b};
  assign prod_su = {{XLEN{src_a[XLEN-1]}}, src_a} * {{XLEN{1'b0}}, src_b};
  assign prod_uu = {{XLEN{1'b0}}, src_a} * {{XLEN{1'b0}}, src_b};

  logic unused_prod_bits;
  assign unused_prod_bits = ^{prod_ss[XLEN-1:0], prod_su[XLEN-1:0]};

  assign div_zero = (src_b == '0);
  assign div_ovf  = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);

  always_comb begin
    alu_res = '0;
    case (ctrl.alu_op)
      ALU_ADD:    alu_res = src_a + src_b;
      ALU_SUB:    alu_res = src_a - src_b;
      ALU_AND:    alu_res = src_a & src_b;
      ALU_OR:     alu_res = src_a | src_b;
      ALU_XOR:    alu_res = src_a ^ src_b;
      ALU_SLL:    alu_res = src_a << src_b[4:0];
      ALU_SRL:    alu_res = src_a >> src_b[4:0];
      ALU_SRA:    alu_res = 32'($signed(src_a) >>> src_b[4:0]);
      ALU_SLT:    alu_res = {31'b0, $signed(src_a) < $signed(src_b)};
      ALU_SLTU:   alu_res = {31'b0, src_a < src_b};
      ALU_MUL:    alu_res = prod_uu[XLEN-1:0];
      ALU_MULH:   alu_res = prod_ss[2*XLEN-1:XLEN];
      ALU_MULHSU: alu_res = prod_su[2*XLEN-1:XLEN];
      ALU_MULHU:  alu_res = prod_uu[2*XLEN-1:XLEN];
      ALU_DIV: begin
        if (div_zero)     alu_res = '1;
        else if (div_ovf) alu_res = 32'h8000_0000;
        else              alu_res = 32'($signed(src_a) / $signed(src_b));
      end
      ALU_DIVU:   alu_res = div_zero ? '1 : src_a / src_b;
      ALU_REM: begin
        if (div_zero)     alu_res = src_a;
        else if (div_ovf) alu_res = '0;
        else              alu_res = 32'($signed(src_a) % $signed(src_b));
      end
      ALU_REMU:   alu_res = div_zero ? src_a : src_a % src_b;
      ALU_PASSB:  alu_res = src_b;
      default:    alu_res = '0;
    endcase
  end

  assign zero = (alu_res == '0);

  // Branch condition and redirect target
  logic            taken;
  logic            redirect;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_imm;
  logic [XLEN-1:0] pc_target;

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = $signed(rs1_data_i) < $signed(rs2_data_i);
      3'b101:  taken = !($signed(rs1_data_i) < $signed(rs2_data_i));
      3'b110:  taken = rs1_data_i < rs2_data_i;
      3'b111:  taken = !(rs1_data_i < rs2_data_i);
      default: taken = 1'b0;
    endcase
  end

  assign redirect = valid_i && (ctrl.jump || (ctrl.branch && taken));

  rv32im_exec_slice_add32 u_pc_plus4 (
    .a   (pc_i),
    .b   (32'd4),
    .sum (pc_plus4)
  );

  rv32im_exec_slice_add32 u_pc_imm (
    .a   (pc_i),
    .b   (imm_i),
    .sum (pc_imm)
  );

  assign pc_target = ctrl.jalr ? {alu_res[XLEN-1:1], 1'b0} : pc_imm;

  // EX/MEM register; bubbles clear the enables but datapath fields follow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_result_o <= '0;
      write_data_o <= '0;
      pc_plus4_o   <= '0;
      pc_target_o  <= '0;
      pcsrc_o      <= 1'b0;
      reg_write_o  <= 1'b0;
      result_src_o <= '0;
      mem_write_o  <= 1'b0;
      rd_o         <= '0;
      illegal_o    <= 1'b0;
    end else begin
      alu_result_o <= alu_res;
      write_data_o <= rs2_data_i;
      pc_plus4_o   <= pc_plus4;
      pc_target_o  <= pc_target;
      pcsrc_o      <= redirect;
      reg_write_o  <= valid_i && ctrl.reg_write;
      result_src_o <= ctrl.result_src;
      mem_write_o  <= valid_i && ctrl.mem_write;
      rd_o         <= instr_i[11:7];
      illegal_o    <= valid_i && ctrl.illegal;
    end
  end

endmodule

// File: tb/tb_rv32im_exec_slice.sv
// Self-checking bench for rv32im_exec_slice: directed instruction steps,
// expected EX/MEM fields queued at drive time and compared one cycle later.
module tb_rv32im_exec_slice;

  logic        clk;
  logic        reset;
  logic        valid_i;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [31:0] imm_i;
  logic [2:0]  imm_src_o;
  logic [31:0] alu_result_o;
  logic [31:0] write_data_o;
  logic [31:0] pc_plus4_o;
  logic [31:0] pc_target_o;
  logic        pcsrc_o;
  logic        reg_write_o;
  logic [1:0]  result_src_o;
  logic        mem_write_o;
  logic [4:0]  rd_o;
  logic        illegal_o;

  rv32im_exec_slice dut (
    .clk          (clk),
    .reset        (reset),
    .valid_i      (valid_i),
    .instr_i      (instr_i),
    .pc_i         (pc_i),
    .rs1_data_i   (rs1_data_i),
    .rs2_data_i   (rs2_data_i),
    .imm_i        (imm_i),
    .imm_src_o    (imm_src_o),
    .alu_result_o (alu_result_o),
    .write_data_o (write_data_o),
    .pc_plus4_o   (pc_plus4_o),
    .pc_target_o  (pc_target_o),
    .pcsrc_o      (pcsrc_o),
    .reg_write_o  (reg_write_o),
    .result_src_o (result_src_o),
    .mem_write_o  (mem_write_o),
    .rd_o         (rd_o),
    .illegal_o    (illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [31:0] pcp4;
    logic [31:0] tgt;
    logic        pcsrc;
    logic        regw;
    logic [1:0]  rsrc;
    logic        memw;
    logic [4:0]  rd;
    logic        ill;
    logic        chk_alu;
    logic        chk_tgt;
    logic        chk_rsrc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_passed = 0;

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_passed++;
    else $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
  endtask

  function automatic exp_t mk(input logic [31:0] alu, input logic [31:0] wdata,
                              input logic [31:0] pcp4, input logic [31:0] tgt,
                              input logic pcsrc, input logic regw, input logic [1:0] rsrc,
                              input logic memw, input logic [4:0] rd, input logic ill,
                              input logic chk_alu, input logic chk_tgt, input logic chk_rsrc);
    exp_t e;
    e.alu = alu; e.wdata = wdata; e.pcp4 = pcp4; e.tgt = tgt;
    e.pcsrc = pcsrc; e.regw = regw; e.rsrc = rsrc; e.memw = memw;
    e.rd = rd; e.ill = ill;
    e.chk_alu = chk_alu; e.chk_tgt = chk_tgt; e.chk_rsrc = chk_rsrc;
    return e;
  endfunction

  // Compare registered outputs against the oldest queued expectation
  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      $error("FAIL %s: observed=empty-scoreboard expected=entry", tag);
      return;
    end
    e = sb.pop_front();
    if (e.chk_alu)  cmp({tag, ".alu"}, alu_result_o, e.alu);
    cmp({tag, ".wdata"}, write_data_o, e.wdata);
    cmp({tag, ".pcp4"}, pc_plus4_o, e.pcp4);
    if (e.chk_tgt)  cmp({tag, ".tgt"}, pc_target_o, e.tgt);
    cmp({tag, ".pcsrc"}, 32'(pcsrc_o), 32'(e.pcsrc));
    cmp({tag, ".regw"}, 32'(reg_write_o), 32'(e.regw));
    if (e.chk_rsrc) cmp({tag, ".rsrc"}, 32'(result_src_o), 32'(e.rsrc));
    cmp({tag, ".memw"}, 32'(mem_write_o), 32'(e.memw));
    cmp({tag, ".rd"}, 32'(rd_o), 32'(e.rd));
    cmp({tag, ".ill"}, 32'(illegal_o), 32'(e.ill));
  endtask

  // Drive one instruction, check imm_src combinationally, then the registered result
  task automatic step(input string tag, input logic v, input logic [31:0] ins,
                      input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2,
                      input logic [31:0] im, input logic [2:0] exp_imm_src, input exp_t e);
    @(negedge clk);
    valid_i = v; instr_i = ins; pc_i = pc;
    rs1_data_i = r1; rs2_data_i = r2; imm_i = im;
    #1;
    cmp({tag, ".imm_src"}, 32'(imm_src_o), 32'(exp_imm_src));
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  task automatic check_all_zero(input string tag);
    cmp({tag, ".alu"}, alu_result_o, 32'h0);
    cmp({tag, ".wdata"}, write_data_o, 32'h0);
    cmp({tag, ".pcp4"}, pc_plus4_o, 32'h0);
    cmp({tag, ".tgt"}, pc_target_o, 32'h0);
    cmp({tag, ".ctl"}, {24'h0, pcsrc_o, reg_write_o, result_src_o, mem_write_o, illegal_o, 2'b0}, 32'h0);
    cmp({tag, ".rd"}, 32'(rd_o), 32'h0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; valid_i = 1'b0; instr_i = '0; pc_i = '0;
    rs1_data_i = '0; rs2_data_i = '0; imm_i = '0;
    #3 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset_init");
    @(negedge clk) reset = 1'b1;

    //              tag        v     instr          pc          rs1           rs2           imm          isrc
    step("add",     1'b1, 32'h002081B3, 32'h0,      32'd5,        32'd7,        32'h0,       3'b000,
         mk(32'd12, 32'd7, 32'h4, 32'h0, 0, 1, 2'b00, 0, 5'd3, 0, 1, 0, 1));
    step("sub",     1'b1, 32'h402081B3, 32'h10,     32'd5,        32'd7,        32'h0,       3'b000,
         mk(32'hFFFFFFFE, 32'd7, 32'h14, 32'h0, 0, 1, 2'b00, 0, 5'd3, 0, 1, 0, 1));
    step("div_ovf", 1'b1, 32'h0220C1B3, 32'h20,     32'h80000000, 32'hFFFFFFFF, 32'h0,       3'b000,
         mk(32'h80000000, 32'hFFFFFFFF, 32'h24, 32'h0, 0, 1, 2'b00, 0, 5'd3, 0, 1, 0, 1));
    step("divu_z",  1'b1, 32'h0220D1B3, 32'h24,     32'd123,      32'h0,        32'h0,       3'b000,
         mk(32'hFFFFFFFF, 32'h0, 32'h28, 32'h0, 0, 1, 2'b00, 0, 5'd3, 0, 1, 0, 1));
    step("rem_z",   1'b1, 32'h0220E1B3, 32'h28,     32'd9,        32'h0,        32'h0,       3'b000,
         mk(32'd9, 32'h0, 32'h2C, 32'h0, 0, 1, 2'b00, 0, 5'd3, 0, 1, 0, 1));
    step("mul",     1'b1, 32'h022081B3, 32'h2C,     32'd3,        32'd5,        32'h0,       3'b000,
         mk(32'd15, 32'd5, 32'h30, 32'h0, 0, 1, 2'b00, 0, 5'd3, 0, 1, 0, 1));
    step("mulh",    1'b1, 32'h022091B3, 32'h30,     32'h80000000, 32'd2,        32'h0,       3'b000,
         mk(32'hFFFFFFFF, 32'd2, 32'h34, 32'h0, 0, 1, 2'b00, 0, 5'd3, 0, 1, 0, 1));
    step("mulhu",   1'b1, 32'h0220B1B3, 32'h34,     32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,       3'b000,
         mk(32'hFFFFFFFE, 32'hFFFFFFFF, 32'h38, 32'h0, 0, 1, 2'b00, 0, 5'd3, 0, 1, 0, 1));
    step("srai",    1'b1, 32'h4040D193, 32'h38,     32'h80000000, 32'h0,        32'h00000404, 3'b000,
         mk(32'hF8000000, 32'h0, 32'h3C, 32'h0, 0, 1, 2'b00, 0, 5'd3, 0, 1, 0, 1));
    step("addi_b30",1'b1, 32'h40008193, 32'h3C,     32'd1,        32'h0,        32'h00000400, 3'b000,
         mk(32'h401, 32'h0, 32'h40, 32'h0, 0, 1, 2'b00, 0, 5'd3, 0, 1, 0, 1));
    step("lw",      1'b1, 32'h0080A183, 32'h40,     32'h1000,     32'h0,        32'd8,       3'b000,
         mk(32'h1008, 32'h0, 32'h44, 32'h0, 0, 1, 2'b01, 0, 5'd3, 0, 1, 0, 1));
    step("sw",      1'b1, 32'h0020A623, 32'h44,     32'h2000,     32'hDEADBEEF, 32'd12,      3'b001,
         mk(32'h200C, 32'hDEADBEEF, 32'h48, 32'h0, 0, 0, 2'b00, 1, 5'd12, 0, 1, 0, 0));
    step("bne_t",   1'b1, 32'h02209063, 32'h100,    32'd1,        32'd2,        32'h20,      3'b010,
         mk(32'h0, 32'd2, 32'h104, 32'h120, 1, 0, 2'b00, 0, 5'd0, 0, 0, 1, 0));
    step("bne_nt",  1'b1, 32'h02209063, 32'h100,    32'd2,        32'd2,        32'h20,      3'b010,
         mk(32'h0, 32'd2, 32'h104, 32'h120, 0, 0, 2'b00, 0, 5'd0, 0, 0, 1, 0));
    step("blt_t",   1'b1, 32'h0220C063, 32'h200,    32'hFFFFFFFF, 32'd1,        32'hFFFFFFF0, 3'b010,
         mk(32'h0, 32'd1, 32'h204, 32'h1F0, 1, 0, 2'b00, 0, 5'd0, 0, 0, 1, 0));
    step("bltu_nt", 1'b1, 32'h0220E063, 32'h200,    32'hFFFFFFFF, 32'd1,        32'hFFFFFFF0, 3'b010,
         mk(32'h0, 32'd1, 32'h204, 32'h1F0, 0, 0, 2'b00, 0, 5'd0, 0, 0, 1, 0));
    step("jal",     1'b1, 32'h008000EF, 32'h200,    32'h0,        32'h0,        32'd8,       3'b011,
         mk(32'h0, 32'h0, 32'h204, 32'h208, 1, 1, 2'b10, 0, 5'd1, 0, 0, 1, 1));
    step("lui",     1'b1, 32'h123451B7, 32'h300,    32'hAAAA,     32'h0,        32'h12345000, 3'b100,
         mk(32'h12345000, 32'h0, 32'h304, 32'h0, 0, 1, 2'b00, 0, 5'd3, 0, 1, 0, 1));
    step("auipc",   1'b1, 32'h00001197, 32'h300,    32'h5555,     32'h0,        32'h1000,    3'b100,
         mk(32'h1300, 32'h0, 32'h304, 32'h0, 0, 1, 2'b00, 0, 5'd3, 0, 1, 0, 1));
    step("illegal", 1'b1, 32'h0000007F, 32'h400,    32'd1,        32'd2,        32'h0,       3'b000,
         mk(32'h0, 32'd2, 32'h404, 32'h0, 0, 0, 2'b00, 0, 5'd0, 1, 0, 0, 0));
    step("bub_add", 1'b0, 32'h002081B3, 32'h500,    32'd5,        32'd7,        32'h0,       3'b000,
         mk(32'd12, 32'd7, 32'h504, 32'h0, 0, 0, 2'b00, 0, 5'd3, 0, 1, 0, 1));
    step("bub_jal", 1'b0, 32'h008000EF, 32'h600,    32'h0,        32'h0,        32'd8,       3'b011,
         mk(32'h0, 32'h0, 32'h604, 32'h608, 0, 0, 2'b10, 0, 5'd1, 0, 0, 1, 1));
    step("bub_ill", 1'b0, 32'h0000007F, 32'h700,    32'h0,        32'h0,        32'h0,       3'b000,
         mk(32'h0, 32'h0, 32'h704, 32'h0, 0, 0, 2'b00, 0, 5'd0, 0, 0, 0, 0));
    step("jalr",    1'b1, 32'h004080E7, 32'h40,     32'h1001,     32'h0,        32'd4,       3'b000,
         mk(32'h1005, 32'h0, 32'h44, 32'h1004, 1, 1, 2'b10, 0, 5'd1, 0, 1, 1, 1));

    // Asynchronous reset between clock edges with outputs nonzero
    #2 reset = 1'b0;
    #1 check_all_zero("reset_async");
    @(negedge clk) reset = 1'b1;

    step("post_rst",1'b1, 32'h002081B3, 32'h800,    32'd100,      32'd23,       32'h0,       3'b000,
         mk(32'd123, 32'd23, 32'h804, 32'h0, 0, 1, 2'b00, 0, 5'd3, 0, 1, 0, 1));

    cmp("sb_drained", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
